// File: rtl/bemf_pkg.sv
// Shared constants, state encoding and helpers for the back-EMF scheduler.
package bemf_pkg;

   localparam int unsigned NUM_MOT  = 4;
   localparam int unsigned MOT_W    = 2;
   localparam int unsigned ADC_W    = 10;
   localparam int unsigned BEMF_W   = 16;
   localparam int unsigned PIPE_LAT = 4;

   typedef logic [MOT_W-1:0] mot_t;

   typedef enum logic [2:0] {
      IDLE,
      BLANK,
      SAMPLE,
      WAIT,
      ISSUE,
      WB
   } state_e;

   // One-hot blanking mask for a motor index.
   function automatic logic [NUM_MOT-1:0] mot_onehot(input mot_t m);
      return NUM_MOT'(1) << m;
   endfunction

endpackage

// File: rtl/bemf_rr_pick.sv
// Round-robin picker: first enabled motor searching cur+1, cur+2, ... modulo NUM_MOT.
module bemf_rr_pick
   import bemf_pkg::*;
(
   input  mot_t               cur_i,
   input  logic [NUM_MOT-1:0] mot_en_i,
   output mot_t               next_o,
   output logic               any_o
);

   mot_t idx;

   // Walk offsets from farthest to nearest so the nearest enabled motor wins.
   always_comb begin
      next_o = cur_i;
      idx    = '0;
      any_o  = |mot_en_i;
      for (int unsigned k = NUM_MOT; k >= 1; k--) begin
         idx = cur_i + mot_t'(k);
         if (mot_en_i[idx]) begin
            next_o = idx;
         end
      end
   end

endmodule

// File: rtl/bemf_sched.sv
// Back-EMF sample sequencer and accumulator write-back owner.
// Optional macro BEMF_TIMEOUT_EN adds an ADC-timeout abort with a sticky err flag.
module bemf_sched
   import bemf_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 2000,
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MOT-1:0]        mot_en,
   input  logic [NUM_MOT-1:0]        clear,
   input  logic [NUM_MOT*BEMF_W-1:0] calib_in,
   output logic [NUM_MOT-1:0]        pwm_blank,
   output logic                      adc_start,
   output logic [MOT_W-1:0]          adc_mot,
   input  logic                      adc_done,
   input  logic [ADC_W-1:0]          adc_h,
   input  logic [ADC_W-1:0]          adc_l,
   output logic                      upd_valid,
   output logic [MOT_W-1:0]          upd_mot_sel,
   output logic [ADC_W-1:0]          upd_adc_h,
   output logic [ADC_W-1:0]          upd_adc_l,
   output logic [BEMF_W-1:0]         upd_bemf,
   output logic [BEMF_W-1:0]         upd_calib,
   input  logic                      res_valid,
   input  logic [MOT_W-1:0]          res_mot_sel,
   input  logic [BEMF_W-1:0]         res_bemf,
   output logic [NUM_MOT*BEMF_W-1:0] bemf_acc,
   output logic                      err
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   state_e                          state_q;
   mot_t                            cur_q;
   logic [15:0]                     cnt_q;
   logic                            disc_q;
   logic [NUM_MOT-1:0]              pwm_blank_q;
   logic                            adc_start_q;
   mot_t                            adc_mot_q;
   logic                            upd_valid_q;
   mot_t                            upd_mot_sel_q;
   logic [ADC_W-1:0]                upd_adc_h_q;
   logic [ADC_W-1:0]                upd_adc_l_q;
   logic [BEMF_W-1:0]               upd_bemf_q;
   logic [BEMF_W-1:0]               upd_calib_q;
   logic [NUM_MOT-1:0][BEMF_W-1:0]  acc_q;
   logic [NUM_MOT-1:0][BEMF_W-1:0]  acc_d;
   logic [NUM_MOT-1:0][BEMF_W-1:0]  calib_w;

`ifdef BEMF_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tcnt_q;
   logic        err_q;
`endif

   mot_t pick;
   logic any_en;
   logic res_hit;
   logic wb_en;
   logic eval;

   assign calib_w = calib_in;

   bemf_rr_pick u_pick (
      .cur_i    (cur_q),
      .mot_en_i (mot_en),
      .next_o   (pick),
      .any_o    (any_en)
   );

   // Write-back is accepted only for the in-flight motor; the next pick shares that cycle.
   assign res_hit = (state_q == WB) && res_valid && (res_mot_sel == cur_q);
   assign wb_en   = res_hit && !disc_q && !clear[cur_q];
   assign eval    = (state_q == IDLE) || res_hit;

   // Accumulator next value: write-back first, then per-motor clear overrides.
   always_comb begin
      acc_d = acc_q;
      if (wb_en) begin
         acc_d[cur_q] = res_bemf;
      end
      for (int unsigned m = 0; m < NUM_MOT; m++) begin
         if (clear[m]) begin
            acc_d[m] = '0;
         end
      end
   end

   // Accumulator register bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cur_q         <= mot_t'(NUM_MOT - 1);
         cnt_q         <= '0;
         disc_q        <= 1'b0;
         pwm_blank_q   <= '0;
         adc_start_q   <= 1'b0;
         adc_mot_q     <= '0;
         upd_valid_q   <= 1'b0;
         upd_mot_sel_q <= '0;
         upd_adc_h_q   <= '0;
         upd_adc_l_q   <= '0;
         upd_bemf_q    <= '0;
         upd_calib_q   <= '0;
`ifdef BEMF_TIMEOUT_EN
         tcnt_q        <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         adc_start_q <= 1'b0;
         upd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= IDLE;
            end
            BLANK: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_q     <= SAMPLE;
                  adc_start_q <= 1'b1;
                  adc_mot_q   <= cur_q;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            SAMPLE: begin
               state_q <= WAIT;
`ifdef BEMF_TIMEOUT_EN
               tcnt_q  <= '0;
`endif
            end
            WAIT: begin
               if (adc_done) begin
                  state_q       <= ISSUE;
                  pwm_blank_q   <= '0;
                  upd_valid_q   <= 1'b1;
                  upd_mot_sel_q <= cur_q;
                  upd_adc_h_q   <= adc_h;
                  upd_adc_l_q   <= adc_l;
                  upd_bemf_q    <= acc_d[cur_q];
                  upd_calib_q   <= calib_w[cur_q];
                  disc_q        <= 1'b0;
               end
`ifdef BEMF_TIMEOUT_EN
               else if (tcnt_q == TIMEOUT_LAST) begin
                  state_q     <= IDLE;
                  pwm_blank_q <= '0;
                  err_q       <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + 16'd1;
               end
`endif
            end
            ISSUE: begin
               state_q <= WB;
               if (clear[cur_q]) begin
                  disc_q <= 1'b1;
               end
            end
            WB: begin
               if (clear[cur_q]) begin
                  disc_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // Pick evaluation overrides the case above when idle or on the write-back cycle.
         if (eval) begin
            state_q     <= IDLE;
            pwm_blank_q <= '0;
            if (any_en) begin
               state_q     <= BLANK;
               cur_q       <= pick;
               cnt_q       <= '0;
               pwm_blank_q <= mot_onehot(pick);
            end
         end
      end
   end

   assign pwm_blank   = pwm_blank_q;
   assign adc_start   = adc_start_q;
   assign adc_mot     = adc_mot_q;
   assign upd_valid   = upd_valid_q;
   assign upd_mot_sel = upd_mot_sel_q;
   assign upd_adc_h   = upd_adc_h_q;
   assign upd_adc_l   = upd_adc_l_q;
   assign upd_bemf    = upd_bemf_q;
   assign upd_calib   = upd_calib_q;
   assign bemf_acc    = acc_q;

`ifdef BEMF_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
